// File: rtl/mio_bus_ctrl_if.sv
// CPU data-side bus: request/address/data from the CPU, read data and completion pulse back.
// master = CPU side, slave = bus controller side.
interface mio_bus_ctrl_if;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        mio_ready;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, mio_ready
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, mio_ready
   );
endinterface

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: routes CPU data accesses to RAM (RAM_WAIT wait cycles),
// GPIO LEDs/switches or a countdown timer (single cycle); mio_ready pulses for one cycle.
module mio_bus_ctrl #(
   parameter int RAM_AW   = 10,
   parameter int RAM_WAIT = 2,
   parameter int LED_W    = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   mio_bus_ctrl_if.slave     bus,
   output logic [RAM_AW-1:0] o_ram_addr,
   output logic [31:0]       o_ram_wdata,
   output logic              o_ram_we,
   input  logic [31:0]       i_ram_rdata,
   input  logic [LED_W-1:0]  i_sw,
   output logic [LED_W-1:0]  o_led,
   output logic              o_cnt_irq
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [3:0]          r_wait_cnt;
   logic                r_first;
   logic                r_we_lat;
   logic [RAM_AW-1:0]   r_ram_addr;
   logic [31:0]         r_ram_wdata;
   logic [31:0]         r_cpu_rdata;
   logic [LED_W-1:0]    r_led;
   logic [31:0]         r_count;
   logic [31:0]         r_load;
   logic                r_en;
   logic                r_auto;
   logic                r_flag;

   logic [29:0]         w_word;
   logic                w_is_ram;
   logic                w_sel_gpio;
   logic                w_sel_cnt;
   logic                w_sel_ctrl;
   logic                w_accept;
   logic                w_io_acc;
   logic                w_io_wr;
   logic                w_wr_gpio;
   logic                w_wr_cnt;
   logic                w_wr_ctrl;
   logic                w_wait_done;
   logic                w_cnt_hit;
   logic [31:0]         w_io_rdata;
   logic                w_unused_addr;

   assign w_word        = bus.cpu_addr[31:2];
   assign w_unused_addr = ^bus.cpu_addr[1:0];
   assign w_is_ram      = (bus.cpu_addr[31:28] == 4'h0);
   assign w_sel_gpio    = (w_word == 30'h3C00_0000);
   assign w_sel_cnt     = (w_word == 30'h3C00_0001);
   assign w_sel_ctrl    = (w_word == 30'h3C00_0002);

   assign w_accept      = (r_state == S_IDLE) && bus.cpu_req;
   assign w_io_acc      = w_accept && !w_is_ram;
   assign w_io_wr       = w_io_acc && bus.cpu_we;
   assign w_wr_gpio     = w_io_wr && w_sel_gpio;
   assign w_wr_cnt      = w_io_wr && w_sel_cnt;
   assign w_wr_ctrl     = w_io_wr && w_sel_ctrl;
   assign w_wait_done   = (r_state == S_WAIT) && (r_wait_cnt == 4'd1);

   // Timer event: the 1->0 step, or an enabled counter already sitting at 0.
   assign w_cnt_hit     = r_en && ((r_count == 32'd0) || (r_count == 32'd1));

   always_comb begin
      w_io_rdata = '0;
      if (w_sel_gpio) begin
         w_io_rdata[LED_W-1:0] = i_sw;
      end else if (w_sel_cnt) begin
         w_io_rdata = r_count;
      end else if (w_sel_ctrl) begin
         w_io_rdata = {29'd0, r_flag, r_auto, r_en};
      end
   end

   // FSM: state register
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.cpu_req) begin
               w_state_nxt = w_is_ram ? S_WAIT : S_RESP;
            end
         end
         S_WAIT: begin
            if (w_wait_done) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      bus.mio_ready = (r_state == S_RESP);
      o_ram_we      = (r_state == S_WAIT) && r_first && r_we_lat;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wait_cnt  <= '0;
         r_first     <= 1'b0;
         r_we_lat    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_cpu_rdata <= '0;
      end else begin
         if (w_accept && w_is_ram) begin
            r_ram_addr  <= bus.cpu_addr[RAM_AW+1:2];
            r_ram_wdata <= bus.cpu_wdata;
            r_we_lat    <= bus.cpu_we;
            r_wait_cnt  <= 4'(RAM_WAIT);
            r_first     <= 1'b1;
         end else if (r_state == S_WAIT) begin
            r_first     <= 1'b0;
            r_wait_cnt  <= r_wait_cnt - 4'd1;
         end

         // Writes return 0 so stale read data never leaks into a write completion.
         if (w_io_acc) begin
            r_cpu_rdata <= bus.cpu_we ? 32'd0 : w_io_rdata;
         end else if (w_wait_done) begin
            r_cpu_rdata <= r_we_lat ? 32'd0 : i_ram_rdata;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_led <= '0;
      end else if (w_wr_gpio) begin
         r_led <= bus.cpu_wdata[LED_W-1:0];
      end
   end

   // Timer: CPU count writes beat decrement/reload; hardware flag set beats write-1-to-clear.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_count <= '0;
         r_load  <= '0;
         r_en    <= 1'b0;
         r_auto  <= 1'b0;
         r_flag  <= 1'b0;
      end else begin
         if (w_wr_cnt) begin
            r_count <= bus.cpu_wdata;
            r_load  <= bus.cpu_wdata;
         end else if (w_cnt_hit) begin
            r_count <= r_auto ? r_load : 32'd0;
         end else if (r_en) begin
            r_count <= r_count - 32'd1;
         end

         if (w_wr_ctrl) begin
            r_en   <= bus.cpu_wdata[0];
            r_auto <= bus.cpu_wdata[1];
         end else if (w_cnt_hit && !r_auto) begin
            r_en   <= 1'b0;
         end

         if (w_cnt_hit) begin
            r_flag <= 1'b1;
         end else if (w_wr_ctrl && bus.cpu_wdata[2]) begin
            r_flag <= 1'b0;
         end
      end
   end

   assign bus.cpu_rdata = r_cpu_rdata;
   assign o_ram_addr    = r_ram_addr;
   assign o_ram_wdata   = r_ram_wdata;
   assign o_led         = r_led;
   assign o_cnt_irq     = r_flag;

endmodule
